// File: rtl/um_lb_pkg.sv
// um_lb_pkg: shared state encoding, register map bounds and decode helpers for the local-bus slave
package um_lb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } state_t;

    localparam logic [7:0]  CFG_BASE       = 8'h00;
    localparam logic [7:0]  STAT_BASE      = 8'h10;
    localparam logic [7:0]  MAP_END        = 8'h1F;
    localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

    // Config window is the 16 words starting at CFG_BASE
    function automatic logic is_cfg(input logic [7:0] a);
        return a[7:4] == CFG_BASE[7:4];
    endfunction

    function automatic logic is_stat(input logic [7:0] a);
        return (a >= STAT_BASE) && (a <= MAP_END);
    endfunction

endpackage

// File: rtl/um_lb_slave_if.sv
// um_lb_slave_if: multiplexed address/data local-bus signals between upstream master and slave
interface um_lb_slave_if;

    logic        ale;
    logic        cs_n;
    logic        rd_wr;
    logic [31:0] data;
    logic        ack_n_um;
    logic [31:0] rdata_um;

    modport master (
        output ale, cs_n, rd_wr, data,
        input  ack_n_um, rdata_um
    );

    modport slave (
        input  ale, cs_n, rd_wr, data,
        output ack_n_um, rdata_um
    );

endinterface

// File: rtl/um_lb_regbank.sv
// um_lb_regbank: 16 read/write config registers with write strobes, plus the read-data mux over cfg/status/unmapped space
module um_lb_regbank
    import um_lb_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [7:0]   addr,
    input  logic [31:0]  wdata,
    input  logic [511:0] stat_in,
    output logic [511:0] cfg_regs,
    output logic [15:0]  cfg_wr,
    output logic [31:0]  rdata
);

    logic [15:0][31:0] cfg_q;
    logic [15:0][31:0] stat_w;
    logic [15:0]       cfg_wr_q;

    assign stat_w   = stat_in;
    assign cfg_regs = cfg_q;
    assign cfg_wr   = cfg_wr_q;

    // Commit writes into the config window; the strobe is high for the cycle after the commit edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q    <= '0;
            cfg_wr_q <= '0;
        end else begin
            cfg_wr_q <= '0;
            if (wr_en && is_cfg(addr)) begin
                cfg_q[addr[3:0]]    <= wdata;
                cfg_wr_q[addr[3:0]] <= 1'b1;
            end
        end
    end

    assign rdata = is_cfg(addr)  ? cfg_q[addr[3:0]]  :
                   is_stat(addr) ? stat_w[addr[3:0]] : UNMAPPED_RDATA;

endmodule

// File: rtl/um_lb_slave.sv
// um_lb_slave: local-bus slave FSM decoding one 256-byte page into config, status and unmapped space
module um_lb_slave
    import um_lb_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR = 24'h000001,
    parameter int          ACK_LAT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    um_lb_slave_if.slave bus,
    output logic [511:0] cfg_regs,
    output logic [15:0]  cfg_wr,
    input  logic [511:0] stat_in,
    output logic [15:0]  stat_rd
);

    localparam logic [3:0] CNT_INIT = 4'(ACK_LAT - 1);

    state_t      state_q, state_d;
    logic [7:0]  addr_q;
    logic        dir_q;
    logic [3:0]  cnt_q;
    logic [31:0] rdata_q;
    logic [15:0] stat_rd_q;
    logic [31:0] rmux;
    logic        cap;
    logic        wr_en;
    logic        ack_ent;

    // cap: first data-phase edge; ack_ent: the edge that moves WAIT into ACK
    assign cap     = !bus.ale && state_q == ADDR && !bus.cs_n;
    assign wr_en   = cap && !dir_q;
    assign ack_ent = !bus.ale && state_q == WAIT && !bus.cs_n && cnt_q == 4'd0;

    um_lb_regbank u_regbank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .addr     (addr_q),
        .wdata    (bus.data),
        .stat_in  (stat_in),
        .cfg_regs (cfg_regs),
        .cfg_wr   (cfg_wr),
        .rdata    (rmux)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: a new address phase preempts whatever access is in flight
    always_comb begin
        state_d = state_q;
        if (bus.ale) state_d = (bus.data[31:8] == BASE_ADDR) ? ADDR : IDLE;
        else begin
            unique case (state_q)
                ADDR:    state_d = bus.cs_n ? ADDR : WAIT;
                WAIT:    state_d = bus.cs_n ? IDLE : (cnt_q == 4'd0) ? ACK : WAIT;
                ACK:     state_d = bus.cs_n ? IDLE : ACK;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: acknowledge follows the ACK state directly
    always_comb begin
        bus.ack_n_um = (state_q != ACK);
    end

    // Datapath: address/direction latch, latency counter, read snapshot and status-read strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            dir_q     <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            stat_rd_q <= '0;
        end else begin
            if (bus.ale) begin
                addr_q <= bus.data[7:0];
                dir_q  <= bus.rd_wr;
            end
            if (cap) cnt_q <= CNT_INIT;
            else if (state_q == WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            if (ack_ent && dir_q) rdata_q <= rmux;
            stat_rd_q <= (ack_ent && dir_q && is_stat(addr_q)) ? 16'(1) << addr_q[3:0] : '0;
        end
    end

    assign bus.rdata_um = rdata_q;
    assign stat_rd      = stat_rd_q;

endmodule

// File: tb/tb_um_lb_slave.sv
// tb_um_lb_slave: directed self-checking bench for the local-bus slave
module tb_um_lb_slave;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [511:0]      cfg_regs;
    logic [511:0]      stat_in;
    logic [15:0]       cfg_wr;
    logic [15:0]       stat_rd;
    logic [15:0][31:0] cfg_m;
    logic [15:0][31:0] stat_m;
    int                checks = 0;
    int                errors = 0;
    int                lows;

    assign stat_in = stat_m;

    um_lb_slave_if bus ();

    um_lb_slave #(.BASE_ADDR(24'h000001), .ACK_LAT(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .cfg_regs (cfg_regs),
        .cfg_wr   (cfg_wr),
        .stat_in  (stat_in),
        .stat_rd  (stat_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic rd);
        bus.ale   = 1'b1;
        bus.data  = a;
        bus.rd_wr = rd;
        bus.cs_n  = 1'b1;
        tick;
        bus.ale = 1'b0;
    endtask

    task automatic data_phase(input logic [31:0] d);
        bus.cs_n = 1'b0;
        bus.data = d;
        tick;
    endtask

    initial begin
        bus.ale   = 1'b0;
        bus.cs_n  = 1'b1;
        bus.rd_wr = 1'b0;
        bus.data  = '0;
        cfg_m     = '0;
        for (int i = 0; i < 16; i++) stat_m[i] = 32'h5000_0000 + 32'(i);
        stat_m[2] = 32'h1234_5678;
        tick;
        tick;
        chk("rst_ack", bus.ack_n_um, 1'b1);
        chk("rst_rdata", bus.rdata_um, 32'h0);
        chk("rst_cfg", cfg_regs, '0);
        chk("rst_cfg_wr", cfg_wr, 16'h0);
        chk("rst_stat_rd", stat_rd, 16'h0);
        reset = 1'b0;
        tick;

        addr_phase(32'h0000_0103, 1'b0);
        data_phase(32'hCAFE_0001);
        cfg_m[3] = 32'hCAFE_0001;
        chk("wr3_cfg", cfg_regs, cfg_m);
        chk("wr3_pulse", cfg_wr, 16'h0008);
        chk("wr3_ack_e0", bus.ack_n_um, 1'b1);
        tick;
        chk("wr3_pulse_off", cfg_wr, 16'h0);
        chk("wr3_ack_e1", bus.ack_n_um, 1'b1);
        tick;
        chk("wr3_ack_low", bus.ack_n_um, 1'b0);
        tick;
        chk("wr3_ack_hold", bus.ack_n_um, 1'b0);
        bus.cs_n = 1'b1;
        tick;
        chk("wr3_ack_rel", bus.ack_n_um, 1'b1);

        addr_phase(32'h0000_0112, 1'b1);
        data_phase(32'h0);
        chk("rd12_strb_e0", stat_rd, 16'h0);
        tick;
        chk("rd12_ack_e1", bus.ack_n_um, 1'b1);
        tick;
        chk("rd12_ack_low", bus.ack_n_um, 1'b0);
        chk("rd12_rdata", bus.rdata_um, 32'h1234_5678);
        chk("rd12_strb", stat_rd, 16'h0004);
        stat_m[2] = 32'h0BAD_0002;
        tick;
        chk("rd12_strb_off", stat_rd, 16'h0);
        chk("rd12_snapshot", bus.rdata_um, 32'h1234_5678);
        bus.cs_n = 1'b1;
        tick;
        chk("rd12_ack_rel", bus.ack_n_um, 1'b1);
        chk("rd12_rdata_hold", bus.rdata_um, 32'h1234_5678);

        addr_phase(32'h0000_0103, 1'b1);
        data_phase(32'h0);
        tick;
        tick;
        chk("rd3_ack", bus.ack_n_um, 1'b0);
        chk("rd3_rdata", bus.rdata_um, 32'hCAFE_0001);
        chk("rd3_no_strb", stat_rd, 16'h0);
        bus.cs_n = 1'b1;
        tick;

        addr_phase(32'h0000_0140, 1'b1);
        data_phase(32'h0);
        tick;
        tick;
        chk("rd40_ack", bus.ack_n_um, 1'b0);
        chk("rd40_rdata", bus.rdata_um, 32'hDEAD_BEEF);
        bus.cs_n = 1'b1;
        tick;

        addr_phase(32'h0000_0140, 1'b0);
        data_phase(32'h1111_2222);
        chk("wr40_no_pulse", cfg_wr, 16'h0);
        chk("wr40_cfg", cfg_regs, cfg_m);
        tick;
        tick;
        chk("wr40_ack", bus.ack_n_um, 1'b0);
        bus.cs_n = 1'b1;
        tick;
        chk("wr40_ack_rel", bus.ack_n_um, 1'b1);

        addr_phase(32'h0000_0203, 1'b1);
        bus.cs_n = 1'b0;
        lows = 0;
        repeat (300) begin
            tick;
            if (bus.ack_n_um !== 1'b1) lows++;
        end
        chk("nomatch_ack_lows", lows, 0);
        chk("nomatch_cfg", cfg_regs, cfg_m);
        chk("nomatch_rdata", bus.rdata_um, 32'hDEAD_BEEF);
        bus.cs_n = 1'b1;
        tick;

        addr_phase(32'h0000_0105, 1'b0);
        data_phase(32'hA5A5_0005);
        cfg_m[5] = 32'hA5A5_0005;
        chk("wr5_pulse", cfg_wr, 16'h0020);
        tick;
        tick;
        chk("wr5_ack", bus.ack_n_um, 1'b0);
        bus.cs_n = 1'b1;
        tick;

        addr_phase(32'h0000_0101, 1'b1);
        data_phase(32'h0);
        bus.ale   = 1'b1;
        bus.data  = 32'h0000_0105;
        bus.rd_wr = 1'b1;
        bus.cs_n  = 1'b1;
        tick;
        chk("preempt_no_ack", bus.ack_n_um, 1'b1);
        bus.ale  = 1'b0;
        bus.cs_n = 1'b0;
        tick;
        tick;
        chk("preempt_ack_e1", bus.ack_n_um, 1'b1);
        tick;
        chk("preempt_ack", bus.ack_n_um, 1'b0);
        chk("preempt_rdata", bus.rdata_um, 32'hA5A5_0005);
        bus.cs_n = 1'b1;
        tick;

        addr_phase(32'h0000_010A, 1'b0);
        data_phase(32'h0000_AAAA);
        cfg_m[10] = 32'h0000_AAAA;
        bus.cs_n = 1'b1;
        tick;
        chk("abort_no_ack", bus.ack_n_um, 1'b1);
        tick;
        chk("abort_ack_idle", bus.ack_n_um, 1'b1);
        chk("abort_cfg_kept", cfg_regs, cfg_m);
        bus.cs_n = 1'b0;
        repeat (5) tick;
        chk("idle_ignores_cs", bus.ack_n_um, 1'b1);
        bus.cs_n = 1'b1;
        tick;

        addr_phase(32'h0000_0107, 1'b0);
        data_phase(32'h0000_0777);
        cfg_m[7] = 32'h0000_0777;
        chk("wr7_cfg", cfg_regs, cfg_m);
        tick;
        reset = 1'b1;
        #1;
        cfg_m = '0;
        chk("rst_wait_ack", bus.ack_n_um, 1'b1);
        chk("rst_wait_cfg", cfg_regs, cfg_m);
        chk("rst_wait_rdata", bus.rdata_um, 32'h0);
        tick;
        reset    = 1'b0;
        bus.cs_n = 1'b1;
        tick;
        chk("rst_release_ack", bus.ack_n_um, 1'b1);
        addr_phase(32'h0000_0100, 1'b0);
        data_phase(32'hBEEF_0100);
        cfg_m[0] = 32'hBEEF_0100;
        chk("wr0_cfg", cfg_regs, cfg_m);
        chk("wr0_pulse", cfg_wr, 16'h0001);
        tick;
        tick;
        chk("wr0_ack", bus.ack_n_um, 1'b0);
        bus.cs_n = 1'b1;
        tick;
        chk("wr0_ack_rel", bus.ack_n_um, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
